// File: rtl/reg_handshake_responder.sv
// Register-access responder: round-robin arbitration of three write and
// three read ports against a 16x32 register array, plus a directly loaded PC.
module reg_handshake_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int SVC_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable_1,
  input  logic              write_enable_2,
  input  logic              write_enable_3,
  input  logic [ADDR_W-1:0] write_address_1,
  input  logic [ADDR_W-1:0] write_address_2,
  input  logic [ADDR_W-1:0] write_address_3,
  input  logic [DATA_W-1:0] write_data_1,
  input  logic [DATA_W-1:0] write_data_2,
  input  logic [DATA_W-1:0] write_data_3,
  input  logic              read_enable_1,
  input  logic              read_enable_2,
  input  logic              read_enable_3,
  input  logic [ADDR_W-1:0] in_address_1,
  input  logic [ADDR_W-1:0] in_address_2,
  input  logic [ADDR_W-1:0] in_address_3,
  output logic [DATA_W-1:0] out_data_1,
  output logic [DATA_W-1:0] out_data_2,
  output logic [DATA_W-1:0] out_data_3,
  output logic [2:0]        ack_wr,
  output logic [2:0]        ack_rd,
  output logic              busy,
  input  logic              pc_write,
  input  logic [DATA_W-1:0] pc_update,
  output logic [DATA_W-1:0] pc
);

  localparam int NREGS = 2**ADDR_W;
  localparam int NSLOT = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_SVC,
    S_ACK
  } state_t;

  state_t            r_state;
  logic [2:0]        r_slot;
  logic [2:0]        r_rr;
  logic [5:0]        r_served;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] r_out1;
  logic [DATA_W-1:0] r_out2;
  logic [DATA_W-1:0] r_out3;
  logic [DATA_W-1:0] r_pc;
  logic [2:0]        r_ack_wr;
  logic [2:0]        r_ack_rd;
  logic              r_busy;

  logic [5:0]        w_en;
  logic [5:0]        w_elig;
  logic [5:0]        w_set;
  logic              w_any;
  logic [2:0]        w_pick;
  logic              w_done;
  logic [ADDR_W-1:0] w_gaddr;
  logic [DATA_W-1:0] w_gdata;

  function automatic logic [2:0] f_wrap(input logic [3:0] v);
    logic [3:0] t;
    t = (v >= 4'd6) ? v - 4'd6 : v;
    return t[2:0];
  endfunction

  assign w_en = {read_enable_3, read_enable_2, read_enable_1,
                 write_enable_3, write_enable_2, write_enable_1};
  assign w_elig = w_en & ~r_served;
  assign w_done = (r_state == S_SVC) && (r_cnt == 4'd1);
  assign w_set  = w_done ? (6'd1 << r_slot) : 6'd0;

  // First eligible slot at or after the RR pointer; lowest offset wins
  always_comb begin
    w_any  = 1'b0;
    w_pick = 3'd0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (w_elig[f_wrap({1'b0, r_rr} + 4'(i))]) begin
        w_any  = 1'b1;
        w_pick = f_wrap({1'b0, r_rr} + 4'(i));
      end
    end
  end

  // Address/data of the granted slot, sampled only in GRANT
  always_comb begin
    w_gaddr = in_address_3;
    w_gdata = '0;
    unique case (r_slot)
      3'd0: begin w_gaddr = write_address_1; w_gdata = write_data_1; end
      3'd1: begin w_gaddr = write_address_2; w_gdata = write_data_2; end
      3'd2: begin w_gaddr = write_address_3; w_gdata = write_data_3; end
      3'd3: w_gaddr = in_address_1;
      3'd4: w_gaddr = in_address_2;
      default: w_gaddr = in_address_3;
    endcase
  end

  // Access FSM; ACK also arbitrates so back-to-back accesses need no idle gap
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_slot   <= '0;
      r_rr     <= '0;
      r_served <= '0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_out1   <= '0;
      r_out2   <= '0;
      r_out3   <= '0;
      r_ack_wr <= '0;
      r_ack_rd <= '0;
      r_busy   <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_served <= (r_served & w_en) | w_set;
      r_ack_wr <= w_set[2:0];
      r_ack_rd <= w_set[5:3];
      unique case (r_state)
        S_IDLE, S_ACK: begin
          r_busy <= w_any;
          if (w_any) begin
            r_slot  <= w_pick;
            r_state <= S_GRANT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GRANT: begin
          r_addr  <= w_gaddr;
          r_wdata <= w_gdata;
          r_cnt   <= 4'(SVC_LAT);
          r_state <= S_SVC;
        end
        S_SVC: begin
          if (w_done) begin
            r_state <= S_ACK;
            r_rr    <= f_wrap({1'b0, r_slot} + 4'd1);
            if (r_slot < 3'd3) r_regs[r_addr] <= r_wdata;
            if (w_set[3]) r_out1 <= r_regs[r_addr];
            if (w_set[4]) r_out2 <= r_regs[r_addr];
            if (w_set[5]) r_out3 <= r_regs[r_addr];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // PC load bypasses arbitration entirely
  always_ff @(posedge clk) begin
    if (reset) r_pc <= '0;
    else if (pc_write) r_pc <= pc_update;
  end

  assign out_data_1 = r_out1;
  assign out_data_2 = r_out2;
  assign out_data_3 = r_out3;
  assign ack_wr     = r_ack_wr;
  assign ack_rd     = r_ack_rd;
  assign busy       = r_busy;
  assign pc         = r_pc;

endmodule

// File: tb/tb_reg_handshake_responder.sv
// Directed bench for reg_handshake_responder: single-access vector table
// plus hand-written arbitration, reset-abort and PC sequences.
module tb_reg_handshake_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_enable_1, write_enable_2, write_enable_3;
  logic [3:0]  write_address_1, write_address_2, write_address_3;
  logic [31:0] write_data_1, write_data_2, write_data_3;
  logic        read_enable_1, read_enable_2, read_enable_3;
  logic [3:0]  in_address_1, in_address_2, in_address_3;
  logic [31:0] out_data_1, out_data_2, out_data_3;
  logic [2:0]  ack_wr, ack_rd;
  logic        busy;
  logic        pc_write;
  logic [31:0] pc_update;
  logic [31:0] pc;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          wr;
    int          port;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[8];

  always #5 clk = ~clk;

  reg_handshake_responder dut (
    .clk(clk), .reset(reset),
    .write_enable_1(write_enable_1), .write_enable_2(write_enable_2),
    .write_enable_3(write_enable_3),
    .write_address_1(write_address_1), .write_address_2(write_address_2),
    .write_address_3(write_address_3),
    .write_data_1(write_data_1), .write_data_2(write_data_2),
    .write_data_3(write_data_3),
    .read_enable_1(read_enable_1), .read_enable_2(read_enable_2),
    .read_enable_3(read_enable_3),
    .in_address_1(in_address_1), .in_address_2(in_address_2),
    .in_address_3(in_address_3),
    .out_data_1(out_data_1), .out_data_2(out_data_2), .out_data_3(out_data_3),
    .ack_wr(ack_wr), .ack_rd(ack_rd), .busy(busy),
    .pc_write(pc_write), .pc_update(pc_update), .pc(pc)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_wr(input int k, input logic en, input logic [3:0] a,
                        input logic [31:0] d);
    case (k)
      1: begin write_enable_1 = en; write_address_1 = a; write_data_1 = d; end
      2: begin write_enable_2 = en; write_address_2 = a; write_data_2 = d; end
      default: begin
        write_enable_3 = en; write_address_3 = a; write_data_3 = d;
      end
    endcase
  endtask

  task automatic set_rd(input int k, input logic en, input logic [3:0] a);
    case (k)
      1: begin read_enable_1 = en; in_address_1 = a; end
      2: begin read_enable_2 = en; in_address_2 = a; end
      default: begin read_enable_3 = en; in_address_3 = a; end
    endcase
  endtask

  function automatic logic [31:0] rd_out(input int k);
    case (k)
      1: return out_data_1;
      2: return out_data_2;
      default: return out_data_3;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    write_enable_1 = 0; write_enable_2 = 0; write_enable_3 = 0;
    read_enable_1 = 0; read_enable_2 = 0; read_enable_3 = 0;
    write_address_1 = 0; write_address_2 = 0; write_address_3 = 0;
    write_data_1 = 0; write_data_2 = 0; write_data_3 = 0;
    in_address_1 = 0; in_address_2 = 0; in_address_3 = 0;
    pc_write = 0; pc_update = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One access from an idle responder: ack must land on the 6th negedge
  task automatic access(input vec_t v, input int id);
    int cyc;
    bit got;
    logic [2:0] ak;
    @(posedge clk); #1;
    if (v.wr) set_wr(v.port, 1'b1, v.addr, v.data);
    else set_rd(v.port, 1'b1, v.addr);
    cyc = 0; got = 0; ak = '0;
    while (!got && cyc < 40) begin
      @(negedge clk); cyc++;
      if ((ack_wr | ack_rd) != 3'd0) begin
        got = 1;
        ak = v.wr ? ack_wr : ack_rd;
      end
    end
    check($sformatf("vec%0d_ack_seen", id), 32'(got), 32'd1);
    check($sformatf("vec%0d_ack_port", id), 32'(ak), 32'd1 << (v.port - 1));
    check($sformatf("vec%0d_latency", id), cyc, 32'd6);
    if (!v.wr) check($sformatf("vec%0d_rdata", id), rd_out(v.port), v.exp);
    if (v.wr) set_wr(v.port, 1'b0, v.addr, v.data);
    else set_rd(v.port, 1'b0, v.addr);
    @(negedge clk);
    check($sformatf("vec%0d_ack_once", id), 32'({ack_wr, ack_rd}), 32'd0);
  endtask

  // wr1 and wr2 raised together; each dropped as soon as it is acked
  task automatic pair_write(input logic [3:0] a1, input logic [31:0] d1,
                            input logic [3:0] a2, input logic [31:0] d2,
                            input string nm);
    int c0, c1;
    c0 = 0; c1 = 0;
    @(posedge clk); #1;
    set_wr(1, 1'b1, a1, d1);
    set_wr(2, 1'b1, a2, d2);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (ack_wr[0]) begin c0 = c; write_enable_1 = 0; end
      if (ack_wr[1]) begin c1 = c; write_enable_2 = 0; end
    end
    write_enable_1 = 0; write_enable_2 = 0;
    check({nm, "_wr1_cycle"}, c0, 32'd6);
    check({nm, "_wr2_cycle"}, c1, 32'd11);
  endtask

  initial begin
    int cnt[6];
    int cyc[6];
    int c;
    bit got;
    logic [5:0] a6;

    vt[0] = '{1'b1, 1, 4'd0,  32'h2,        32'h0};
    vt[1] = '{1'b0, 1, 4'd0,  32'h0,        32'h2};
    vt[2] = '{1'b0, 2, 4'd7,  32'h0,        32'h0};
    vt[3] = '{1'b1, 3, 4'd2,  32'hCAFE0001, 32'h0};
    vt[4] = '{1'b0, 3, 4'd2,  32'h0,        32'hCAFE0001};
    vt[5] = '{1'b1, 2, 4'd15, 32'hFFFFFFFF, 32'h0};
    vt[6] = '{1'b0, 1, 4'd15, 32'h0,        32'hFFFFFFFF};
    vt[7] = '{1'b0, 2, 4'd0,  32'h0,        32'h2};

    do_reset();
    @(negedge clk);
    check("rst_pc", pc, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'({ack_wr, ack_rd}), 32'd0);
    check("rst_out1", out_data_1, 32'd0);
    check("rst_out3", out_data_3, 32'd0);

    // T1/T4 and address boundaries
    for (int i = 0; i < 8; i++) access(vt[i], i);

    // T2: simultaneous writes, then read back
    do_reset();
    pair_write(4'd0, 32'h2, 4'd1, 32'h3, "t2");
    access('{1'b0, 1, 4'd0, 32'h0, 32'h2}, 20);
    access('{1'b0, 2, 4'd1, 32'h0, 32'h3}, 21);
    // same address from two writers: later grant (wr2) wins
    pair_write(4'd9, 32'hA, 4'd9, 32'hB, "same_addr");
    access('{1'b0, 3, 4'd9, 32'h0, 32'hB}, 22);

    // T3: all six held high
    do_reset();
    @(posedge clk); #1;
    set_wr(1, 1'b1, 4'd10, 32'h11);
    set_wr(2, 1'b1, 4'd11, 32'h22);
    set_wr(3, 1'b1, 4'd12, 32'h33);
    set_rd(1, 1'b1, 4'd10);
    set_rd(2, 1'b1, 4'd11);
    set_rd(3, 1'b1, 4'd12);
    for (int s = 0; s < 6; s++) begin cnt[s] = 0; cyc[s] = 0; end
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      a6 = {ack_rd, ack_wr};
      for (int s = 0; s < 6; s++) begin
        if (a6[s]) begin
          cnt[s]++;
          if (cnt[s] == 1) cyc[s] = k;
        end
      end
    end
    for (int s = 0; s < 6; s++) begin
      check($sformatf("t3_slot%0d_count", s), cnt[s], 32'd1);
      check($sformatf("t3_slot%0d_cycle", s), cyc[s], 32'(6 + 5 * s));
    end
    check("t3_rd1", out_data_1, 32'h11);
    check("t3_rd2", out_data_2, 32'h22);
    check("t3_rd3", out_data_3, 32'h33);
    write_enable_1 = 0;
    @(negedge clk);
    write_enable_1 = 1;
    c = 0; got = 0; a6 = '0;
    while (!got && c < 20) begin
      @(negedge clk); c++;
      if ((ack_wr | ack_rd) != 3'd0) begin got = 1; a6 = {ack_rd, ack_wr}; end
    end
    check("t3_rearm_seen", 32'(got), 32'd1);
    check("t3_rearm_slot", 32'(a6), 32'd1);
    check("t3_rearm_cycle", c, 32'd5);

    // T5: reset during SERVICE aborts the write
    do_reset();
    @(posedge clk); #1;
    set_wr(1, 1'b1, 4'd5, 32'hDEAD);
    repeat (3) @(negedge clk);
    check("t5_busy_svc", 32'(busy), 32'd1);
    reset = 1'b1;
    write_enable_1 = 0;
    @(negedge clk);
    check("t5_busy_rst", 32'(busy), 32'd0);
    reset = 1'b0;
    c = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ((ack_wr | ack_rd) != 3'd0) c++;
    end
    check("t5_no_ack", c, 32'd0);
    access('{1'b0, 1, 4'd5, 32'h0, 32'h0}, 50);

    // T6: PC load during a write service
    @(posedge clk); #1;
    set_wr(2, 1'b1, 4'd6, 32'h55);
    c = 0; got = 0; a6 = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3) begin pc_write = 1; pc_update = 32'h100; end
      if (k == 4) begin
        check("t6_pc", pc, 32'h100);
        check("t6_busy", 32'(busy), 32'd1);
        pc_write = 0; pc_update = 32'h0;
      end
      if (!got && (ack_wr | ack_rd) != 3'd0) begin
        got = 1; c = k; a6 = {ack_rd, ack_wr};
        write_enable_2 = 0;
      end
    end
    check("t6_ack_cycle", c, 32'd6);
    check("t6_ack_slot", 32'(a6), 32'd2);
    check("t6_pc_hold", pc, 32'h100);
    access('{1'b0, 2, 4'd6, 32'h0, 32'h55}, 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
